// File: rtl/fifo_synch_flush.sv
// Single-clock show-ahead FIFO with oldest-entry flush, occupancy level, almost flags and error pulses.
// Pushes when full and pops when empty are dropped and flagged one cycle later; flags depend only on registered pointers.
module fifo_synch_flush #(
  parameter int DATA_WIDTH    = 8,
  parameter int POINTER_WIDTH = 6,
  parameter int AFULL_THRESH  = (1 << POINTER_WIDTH) - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [POINTER_WIDTH:0]   flush_size,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     full,
  output logic                     empty,
  output logic [POINTER_WIDTH:0]   level,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int DEPTH = 1 << POINTER_WIDTH;
  localparam logic [POINTER_WIDTH:0] DEPTH_LVL = {1'b1, {POINTER_WIDTH{1'b0}}};
  localparam logic [POINTER_WIDTH:0] PTR_ONE   = {{POINTER_WIDTH{1'b0}}, 1'b1};
  localparam logic [POINTER_WIDTH:0] AF_LVL    = (POINTER_WIDTH+1)'(AFULL_THRESH);
  localparam logic [POINTER_WIDTH:0] AE_LVL    = (POINTER_WIDTH+1)'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [POINTER_WIDTH:0] wr_ptr;
  logic [POINTER_WIDTH:0] rd_ptr;
  logic [POINTER_WIDTH:0] flush_n;
  logic                   push_ok;
  logic                   pop_ok;

  // Pointers carry an extra wrap bit, so the raw difference is the occupancy.
  assign level        = wr_ptr - rd_ptr;
  assign full         = (level == DEPTH_LVL);
  assign empty        = (level == '0);
  assign almost_full  = (level >= AF_LVL);
  assign almost_empty = (level <= AE_LVL);
  assign data_out     = mem[rd_ptr[POINTER_WIDTH-1:0]];

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty && !flush;

  always_comb begin
    flush_n = level;
    if (flush_size != '0 && flush_size <= level)
      flush_n = flush_size;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_ONE;
      // Flush wins over pop; the same-cycle push lands behind the flushed range.
      if (flush)
        rd_ptr <= rd_ptr + flush_n;
      else if (pop_ok)
        rd_ptr <= rd_ptr + PTR_ONE;
      overflow  <= push && full;
      underflow <= pop && empty && !flush;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst)
      mem[wr_ptr[POINTER_WIDTH-1:0]] <= data_in;
  end

endmodule

// File: tb/tb_fifo_synch_flush.sv
// Directed and randomized checks of fifo_synch_flush against a queue-based reference model.
module tb_fifo_synch_flush;

  localparam int DW = 8;
  localparam int PW = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          flush = 1'b0;
  logic [PW:0]   flush_size = '0;
  logic [DW-1:0] data_out;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [PW:0]   level;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] q[$];
  logic          exp_ovf = 1'b0;
  logic          exp_udf = 1'b0;

  fifo_synch_flush #(.DATA_WIDTH(DW), .POINTER_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .push(push), .pop(pop),
    .flush(flush), .flush_size(flush_size), .data_out(data_out),
    .full(full), .empty(empty), .level(level), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("level", 32'(level), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(n >= DEPTH - 4));
    chk("almost_empty", 32'(almost_empty), 32'(n <= 4));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("underflow", 32'(underflow), 32'(exp_udf));
    if (n > 0)
      chk("data_out", 32'(data_out), 32'(q[0]));
  endtask

  // One clock: drive at negedge, update model at posedge, check 1 time unit later.
  task automatic cycle(input logic p, input logic o, input logic f,
                       input logic [PW:0] fs, input logic [DW-1:0] d);
    int n, lvl;
    @(negedge clk);
    push = p; pop = o; flush = f; flush_size = fs; data_in = d;
    @(posedge clk);
    lvl = q.size();
    exp_ovf = p && (lvl == DEPTH);
    exp_udf = o && (lvl == 0) && !f;
    if (f) begin
      n = (fs == 0 || int'(fs) > lvl) ? lvl : int'(fs);
      repeat (n) void'(q.pop_front());
    end else if (o && lvl > 0) begin
      void'(q.pop_front());
    end
    if (p && lvl < DEPTH)
      q.push_back(d);
    #1;
    check_all();
  endtask

  task automatic do_push(input logic [DW-1:0] d); cycle(1'b1, 1'b0, 1'b0, '0, d); endtask
  task automatic do_pop();                        cycle(1'b0, 1'b1, 1'b0, '0, '0); endtask
  task automatic do_idle();                       cycle(1'b0, 1'b0, 1'b0, '0, '0); endtask

  task automatic drain();
    while (q.size() > 0) do_pop();
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    do_idle();

    // Fill to full, overflow, drain in order
    for (int i = 1; i <= 64; i++) do_push(DW'(i));
    do_push(8'hAA);
    do_idle();
    for (int i = 1; i <= 64; i++) begin
      chk("fill_order", 32'(data_out), 32'(i));
      do_pop();
    end

    // Wrap with level held at 3
    for (int i = 0; i < 3; i++) do_push(DW'($urandom));
    for (int i = 0; i < 200; i++) begin
      cycle(1'b1, 1'b1, 1'b0, '0, DW'($urandom));
      chk("wrap_level3", 32'(level), 32'd3);
    end
    drain();

    // Partial then total flush
    for (int i = 0; i < 10; i++) do_push(DW'(8'h10 + i));
    cycle(1'b0, 1'b0, 1'b1, 7'd4, '0);
    chk("flush4_head", 32'(data_out), 32'h14);
    chk("flush4_level", 32'(level), 32'd6);
    cycle(1'b0, 1'b0, 1'b1, 7'd0, '0);
    chk("flush0_empty", 32'(empty), 32'd1);

    // Oversized flush with simultaneous push and pop
    for (int i = 0; i < 5; i++) do_push(DW'(8'h20 + i));
    cycle(1'b1, 1'b1, 1'b1, 7'd9, 8'h77);
    chk("flush9_level", 32'(level), 32'd1);
    chk("flush9_head", 32'(data_out), 32'h77);
    chk("flush9_udf", 32'(underflow), 32'd0);
    drain();

    // Flush on empty: no effect, no error
    cycle(1'b0, 1'b1, 1'b1, 7'd3, '0);

    // Pop on empty with push, then pop alone on empty
    cycle(1'b1, 1'b1, 1'b0, '0, 8'h55);
    chk("udf_push_head", 32'(data_out), 32'h55);
    do_pop();
    do_pop();
    chk("udf_alone", 32'(underflow), 32'd1);
    do_idle();

    // Reset mid-stream with push active
    for (int i = 0; i < 30; i++) do_push(DW'($urandom));
    @(negedge clk);
    rst = 1'b1; push = 1'b1; data_in = 8'hEE;
    q.delete(); exp_ovf = 1'b0; exp_udf = 1'b0;
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0; push = 1'b0;
    do_push(8'h99);
    chk("post_rst_head", 32'(data_out), 32'h99);
    drain();

    // Randomized traffic, biased so the FIFO visits both full and empty
    for (int i = 0; i < 3000; i++) begin
      int bias;
      logic p, o, f;
      bias = (i / 300) % 2 == 0 ? 75 : 25;
      p = ($urandom_range(99) < bias);
      o = ($urandom_range(99) < 100 - bias);
      f = ($urandom_range(99) < 3);
      cycle(p, o, f, (PW+1)'($urandom_range(70)), DW'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_synch_flush.md
# fifo_synch_flush

Parametrised synchronous FIFO. Successor to the single-depth router FIFO: adds a partial/total flush of the oldest entries, occupancy level, programmable almost-full/almost-empty flags, and overflow/underflow error pulses. It sits between the router input parser and the output arbiter, one instance per channel. Drop-in buffering for any single-clock producer/consumer pair in the design.

## Interface
- DATA_WIDTH, 8, width of one entry
- POINTER_WIDTH, 6, log2 of depth; DEPTH = 2^POINTER_WIDTH (64)
- AFULL_THRESH, DEPTH-4, almost_full asserted when level >= this value
- AEMPTY_THRESH, 4, almost_empty asserted when level <= this value

- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- data_in  in  DATA_WIDTH  write data, sampled with push
- push  in  1  write request
- pop  in  1  read request (consumes head entry)
- flush  in  1  discard oldest entries, one-cycle request
- flush_size  in  POINTER_WIDTH+1  entries to discard; 0 means discard all
- data_out  out  DATA_WIDTH  head entry (show-ahead); valid only when !empty
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- level  out  POINTER_WIDTH+1  current occupancy, 0..DEPTH
- almost_full  out  1  level >= AFULL_THRESH
- almost_empty  out  1  level <= AEMPTY_THRESH
- overflow  out  1  one-cycle pulse: push rejected
- underflow  out  1  one-cycle pulse: pop rejected

## Operation
- Storage: DEPTH x DATA_WIDTH array, not reset. Read and write pointers are POINTER_WIDTH+1 bits (MSB = wrap bit), wrap naturally modulo 2*DEPTH.
- level = wr_ptr - rd_ptr (mod 2^(POINTER_WIDTH+1)); full/empty/almost flags are derived combinationally from the registered pointers only.
- Push accepted iff push && !full (pre-edge full); writes mem[wr_ptr[POINTER_WIDTH-1:0]], wr_ptr += 1.
- Push && full: data dropped, wr_ptr unchanged, overflow = 1 next cycle. No simultaneous push-through on full, even with pop.
- Pop accepted iff pop && !empty && !flush; rd_ptr += 1.
- Pop && empty (no flush): underflow = 1 next cycle. A push in the same cycle is still accepted; the pop is not satisfied by it.
- Flush: n = (flush_size == 0 || flush_size > level) ? level : flush_size, using pre-edge level; rd_ptr += n. Pop in the same cycle is ignored (flush has priority, no underflow). Push in the same cycle is evaluated normally; the entry written is never discarded by that flush.
- Flush with level == 0: no effect, no error.
- overflow/underflow are registered and cleared every cycle unless re-triggered.

## Timing
- Reset (async assert, sync release on clk): rd_ptr = wr_ptr = 0 → empty=1, full=0, level=0, almost_empty=1, almost_full=0, overflow=0, underflow=0; data_out undefined.
- Reset mid-operation discards all contents immediately; no access completes in the cycle rst is high.
- Write-to-read latency: 1 cycle; an entry pushed at edge k is visible on data_out and counted in level after edge k.
- data_out follows rd_ptr combinationally: after a pop or flush edge it presents the new head in the same cycle.
- All flags and level change only after a clock edge, never combinationally from push/pop/flush.
- Throughput: one push and one pop per cycle sustained when 0 < level < DEPTH; level unchanged.

## Test plan
- Reset, push 0x01..0x40 (64 writes) → full=1, level=64, almost_full from 60th push; 65th push 0xAA → overflow pulse 1 cycle, level stays 64; pop 64 → data_out 0x01..0x40 in order, empty=1.
- Wrap: push/pop 200 interleaved entries with level held at 3 → data order preserved across pointer MSB toggles, full never asserted.
- Load 10 entries 0x10..0x19, flush with flush_size=4 → level=6, data_out=0x14; flush_size=0 → level=0, empty=1.
- Load 5, flush_size=9 with push 0x77 and pop in same cycle → level=1, data_out=0x77, underflow=0.
- Empty FIFO: pop with push 0x55 → underflow pulse, level=1, data_out=0x55; pop alone on empty → underflow, pointers unchanged.
- Load 30 entries, assert rst for one cycle mid-stream with push active → all outputs at reset values, next push 0x99 appears on data_out with level=1.
